// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : Configurable UART receiver. It has a 2-flop input synchroniser,
//               a mid-bit sampling FSM, optional odd/even parity, 1 or 2 stop
//               bits and a valid/ready output stage with overrun detection.
// Ports       : clk         - system clock, rising edge
//               rst_n       - asynchronous active-low reset
//               rx          - serial line, idle high
//               data        - received word, LSB = first data bit
//               data_valid  - data and flags hold a word awaiting transfer
//               data_ready  - consumer accepts the word when data_valid is high
//               parity_err  - parity mismatch on the held word
//               frame_err   - a stop bit was sampled low on the held word
//               overrun     - frame(s) dropped while the held word waited
//               busy        - receiver is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = BAUD_COUNT / 2;
  localparam int CW         = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;

  localparam logic [CW-1:0] C_LAST      = CW'(BAUD_COUNT - 1);
  localparam logic [CW-1:0] C_HALF_M1   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);
  localparam logic [3:0]    C_BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic          C_ODD       = (PARITY == 1);
  localparam logic          C_STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BREAK = 3'd5;

  logic                 sync1_q, rxs_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 w_tick, w_done, w_fe, w_xfer;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, pe_q, fe_q, ov_q;

  // Synchroniser resets to the idle line level so release never fakes a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  assign w_tick = (cnt_q == C_LAST);

  // Next-state logic; w_done marks the final sample cycle of a frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    w_done  = 1'b0;
    w_fe    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == C_HALF_M1) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            stop_d  = 1'b0;
            par_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == C_BIT_LAST) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      S_PAR: begin
        if (w_tick) begin
          cnt_d   = '0;
          par_d   = (((^shift_q) ^ rxs_q) != C_ODD);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          cnt_d = '0;
          if (!rxs_q) begin
            // Low stop bit ends the frame at once; remaining stops skipped.
            w_done  = 1'b1;
            w_fe    = 1'b1;
            state_d = S_BREAK;
          end else if (stop_q == C_STOP_LAST) begin
            w_done  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      S_BREAK: begin
        // Wait for the line to return high so a held-low line is one frame.
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign w_xfer = valid_q & data_ready;

  // Output holding stage: a completing frame is dropped only if the held word
  // is still waiting and is not being taken in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else if (w_done) begin
      if (!valid_q || w_xfer) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
        pe_q    <= par_q;
        fe_q    <= w_fe;
        ov_q    <= 1'b0;
      end else begin
        ov_q <= 1'b1;
      end
    end else if (w_xfer) begin
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_cfg
// Description : Self-checking bench for uart_rx_cfg. Unit 0 is 8N1, unit 1 is
//               8E2. Both use 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

  localparam int BC = 16;
  localparam int HB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] rx_l = 2'b11;
  logic [1:0] rdy_l = 2'b00;
  logic [7:0] data0, data1;
  logic       dv0, pe0, fe0, ov0, busy0;
  logic       dv1, pe1, fe1, ov1, busy1;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .data(data0), .data_valid(dv0),
    .data_ready(rdy_l[0]), .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(busy0));

  uart_rx_cfg #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .data(data1), .data_valid(dv1),
    .data_ready(rdy_l[1]), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(busy1));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drv_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation monitor, sampled on the falling edge.
  int         rises[2]    = '{0, 0};
  int         rise_cyc[2] = '{0, 0};
  int         dv_cyc[2]   = '{0, 0};
  int         busy_cyc[2] = '{0, 0};
  logic       prev_dv[2]  = '{1'b0, 1'b0};
  logic [7:0] cap_data[2];
  logic       cap_pe[2], cap_fe[2], cap_ov[2];

  always @(negedge clk) begin
    if (dv0 && !prev_dv[0]) begin
      rises[0]++; rise_cyc[0] = cyc;
      cap_data[0] = data0; cap_pe[0] = pe0; cap_fe[0] = fe0; cap_ov[0] = ov0;
    end
    if (dv1 && !prev_dv[1]) begin
      rises[1]++; rise_cyc[1] = cyc;
      cap_data[1] = data1; cap_pe[1] = pe1; cap_fe[1] = fe1; cap_ov[1] = ov1;
    end
    if (dv0) dv_cyc[0]++;
    if (dv1) dv_cyc[1]++;
    if (busy0) busy_cyc[0]++;
    if (busy1) busy_cyc[1]++;
    prev_dv[0] = dv0;
    prev_dv[1] = dv1;
  end

  // Reference model of the held word per unit.
  logic [7:0] m_data[2];
  logic       m_valid[2], m_pe[2], m_fe[2], m_ov[2];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_data[u] = 8'h00; m_valid[u] = 1'b0; m_pe[u] = 1'b0; m_fe[u] = 1'b0; m_ov[u] = 1'b0;
    end
  endtask

  task automatic model_frame(input int u, input logic [7:0] d, input logic pe, input logic fe);
    if (!m_valid[u]) begin
      m_valid[u] = 1'b1; m_data[u] = d; m_pe[u] = pe; m_fe[u] = fe; m_ov[u] = 1'b0;
    end else begin
      m_ov[u] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_held(input int u, input string tag);
    if (u == 0) begin
      chk({tag, ".dv"}, 32'(dv0), 32'(m_valid[0]));
      chk({tag, ".data"}, 32'(data0), 32'(m_data[0]));
      chk({tag, ".pe"}, 32'(pe0), 32'(m_pe[0]));
      chk({tag, ".fe"}, 32'(fe0), 32'(m_fe[0]));
      chk({tag, ".ov"}, 32'(ov0), 32'(m_ov[0]));
    end else begin
      chk({tag, ".dv"}, 32'(dv1), 32'(m_valid[1]));
      chk({tag, ".data"}, 32'(data1), 32'(m_data[1]));
      chk({tag, ".pe"}, 32'(pe1), 32'(m_pe[1]));
      chk({tag, ".fe"}, 32'(fe1), 32'(m_fe[1]));
      chk({tag, ".ov"}, 32'(ov1), 32'(m_ov[1]));
    end
  endtask

  function automatic logic busy_of(input int u);
    return (u == 0) ? busy0 : busy1;
  endfunction

  // Each bit occupies BC clock periods.
  task automatic bit_drive(input int u, input logic v);
    @(posedge clk);
    #1;
    rx_l[u] = v;
    drv_cyc = cyc;
    repeat (BC - 1) @(posedge clk);
  endtask

  task automatic send_frame(input int u, input logic [7:0] d, input logic pbit,
                            input logic stop1, output int fall);
    bit_drive(u, 1'b0);
    fall = drv_cyc;
    for (int i = 0; i < 8; i++) bit_drive(u, d[i]);
    if (u == 1) bit_drive(u, pbit);
    bit_drive(u, stop1);
    if (u == 1) bit_drive(u, 1'b1);
  endtask

  // Cycles from rx falling to data_valid: 2 sync + 1 detect + half bit, then
  // one full bit per data/parity bit and per stop bit up to the last one.
  function automatic int exp_lat(input int u);
    return 3 + HB + BC * (8 + ((u == 1) ? 3 : 1));
  endfunction

  task automatic good_frame(input int u, input logic [7:0] d, input logic pbit, input string tag);
    logic was_valid;
    logic pe;
    int   r0, fall;
    pe = (u == 1) ? (((^d) ^ pbit) != 1'b0) : 1'b0;
    was_valid = m_valid[u];
    r0 = rises[u];
    send_frame(u, d, pbit, 1'b1, fall);
    idle(2);
    model_frame(u, d, pe, 1'b0);
    chk({tag, ".rises"}, 32'(rises[u] - r0), was_valid ? 32'd0 : 32'd1);
    if (!was_valid) chk({tag, ".lat"}, 32'(rise_cyc[u] - fall), 32'(exp_lat(u)));
    check_held(u, tag);
    chk({tag, ".busy"}, 32'(busy_of(u)), 32'd0);
  endtask

  task automatic consume(input int u, input string tag);
    check_held(u, {tag, ".pre"});
    @(posedge clk); #1;
    rdy_l[u] = 1'b1;
    @(posedge clk); #1;
    rdy_l[u] = 1'b0;
    m_valid[u] = 1'b0; m_pe[u] = 1'b0; m_fe[u] = 1'b0; m_ov[u] = 1'b0;
    check_held(u, {tag, ".post"});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int         r0, b0, c0, fall, n;
    logic [7:0] d;
    logic       p;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_held(0, "rst0");
    check_held(1, "rst1");
    chk("rst0.busy", 32'(busy0), 32'd0);
    chk("rst1.busy", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single 8N1 frame with consumer always ready.
    r0 = rises[0]; c0 = dv_cyc[0];
    rdy_l[0] = 1'b1;
    send_frame(0, 8'hA5, 1'b0, 1'b1, fall);
    idle(2);
    rdy_l[0] = 1'b0;
    chk("a5.rises", 32'(rises[0] - r0), 32'd1);
    chk("a5.dvcyc", 32'(dv_cyc[0] - c0), 32'd1);
    chk("a5.lat", 32'(rise_cyc[0] - fall), 32'(exp_lat(0)));
    chk("a5.data", 32'(cap_data[0]), 32'hA5);
    chk("a5.flags", {29'd0, cap_pe[0], cap_fe[0], cap_ov[0]}, 32'd0);
    chk("a5.busy", 32'(busy0), 32'd0);
    m_data[0] = 8'hA5;
    check_held(0, "a5.after");

    // Even parity unit.
    good_frame(1, 8'h03, 1'b1, "par1");
    chk("par1.pe_direct", 32'(pe1), 32'd1);
    consume(1, "par1c");
    good_frame(1, 8'h03, 1'b0, "par0");
    chk("par0.pe_direct", 32'(pe1), 32'd0);
    consume(1, "par0c");

    // Random frames, sometimes several before a consume (overrun).
    for (int it = 0; it < 5; it++) begin
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        good_frame(0, d, 1'b0, "rnd0");
      end
      consume(0, "rnd0c");
    end
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(1, 2));
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        p = 1'($urandom);
        good_frame(1, d, p, "rnd1");
      end
      consume(1, "rnd1c");
    end

    // Framing error followed by a long break.
    r0 = rises[0];
    send_frame(0, 8'h5A, 1'b0, 1'b0, fall);
    idle(40 * BC);
    model_frame(0, 8'h5A, 1'b0, 1'b1);
    chk("brk.rises", 32'(rises[0] - r0), 32'd1);
    check_held(0, "brk");
    rx_l[0] = 1'b1;
    idle(2 * BC);
    chk("brk.rises2", 32'(rises[0] - r0), 32'd1);
    chk("brk.busy", 32'(busy0), 32'd0);
    consume(0, "brkc");
    good_frame(0, 8'h3C, 1'b0, "brk.next");
    consume(0, "brk.nextc");

    // Short glitch from idle.
    r0 = rises[0]; b0 = busy_cyc[0];
    @(posedge clk); #1;
    rx_l[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_l[0] = 1'b1;
    idle(40);
    chk("glitch.busy_pulsed", 32'((busy_cyc[0] - b0) > 0), 32'd1);
    chk("glitch.rises", 32'(rises[0] - r0), 32'd0);
    chk("glitch.busy", 32'(busy0), 32'd0);
    check_held(0, "glitch");

    // Back-to-back frames with no consumer.
    r0 = rises[0];
    send_frame(0, 8'h11, 1'b0, 1'b1, fall);
    send_frame(0, 8'h22, 1'b0, 1'b1, fall);
    send_frame(0, 8'h33, 1'b0, 1'b1, fall);
    idle(2);
    model_frame(0, 8'h11, 1'b0, 1'b0);
    model_frame(0, 8'h22, 1'b0, 1'b0);
    model_frame(0, 8'h33, 1'b0, 1'b0);
    consume(0, "ovr");
    idle(40);
    chk("ovr.rises", 32'(rises[0] - r0), 32'd1);

    // Reset in the middle of data bit 3.
    r0 = rises[0];
    d = 8'h96;
    bit_drive(0, 1'b0);
    for (int i = 0; i < 3; i++) bit_drive(0, d[i]);
    @(posedge clk); #1;
    rx_l[0] = d[3];
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_l = 2'b11;
    #1;
    model_reset();
    check_held(0, "mrst0");
    check_held(1, "mrst1");
    chk("mrst0.busy", 32'(busy0), 32'd0);
    chk("mrst1.busy", 32'(busy1), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2 * BC);
    chk("mrst.rises", 32'(rises[0] - r0), 32'd0);
    good_frame(0, 8'hC3, 1'b0, "mrst.c3");
    consume(0, "mrst.c3c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate; BAUD_COUNT = CLK_FREQ/BAUD_RATE (integer, truncated), HALF = BAUD_COUNT/2; BAUD_COUNT SHALL be >= 4.
REQ-003 Parameter DATA_BITS, default 8, legal range 5..9, data bits per frame.
REQ-004 Parameter PARITY, default 0, where 0 = none, 1 = odd and 2 = even.
REQ-005 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 clk  input  1  system clock; all state changes on rising edge.
REQ-007 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-008 rx  input  1  asynchronous serial line, idle high.
REQ-009 data  output  DATA_BITS  received word, LSB = first data bit on the line.
REQ-010 data_valid  output  1  data and flags hold a word awaiting transfer.
REQ-011 data_ready  input  1  consumer accepts the word when data_valid is also high.
REQ-012 parity_err  output  1  parity mismatch on the held word; always 0 when PARITY = 0.
REQ-013 frame_err  output  1  a stop bit was sampled low on the held word.
REQ-014 overrun  output  1  one or more frames were dropped while the held word was waiting.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 Input synchronisation: rx passes through a 2-flop synchroniser (rxs); the FSM uses only rxs.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP and BREAK; one down/up counter of at least clog2(BAUD_COUNT) bits paces all states.
REQ-018 IDLE: when rxs = 0, go to START with counter = 0.
REQ-019 START:
- Sample at counter = HALF-1.
- If rxs = 1 (glitch), return to IDLE with no output change.
- Otherwise clear the counter and enter DATA.
REQ-020 DATA:
- Sample rxs each time counter reaches BAUD_COUNT-1, then restart the counter.
- Shift samples in LSB-first.
- After DATA_BITS samples, go to PARITY if PARITY != 0, else STOP.
REQ-021 PARITY: sample one bit after BAUD_COUNT cycles; mismatch = (XOR of data bits XOR sampled bit) != (PARITY == 1 ? 1 : 0).
REQ-022 STOP:
- Sample STOP_BITS bits at BAUD_COUNT spacing.
- Any low sample sets the frame error and ends the frame at that sample.
- The remaining stop bits are skipped.
REQ-023 Frame completion cycle: the cycle after the final sample, the word, parity mismatch and framing flag are presented on the outputs per REQ-025..027.
- On a framing error, go to BREAK; otherwise go to IDLE.
REQ-024 BREAK: remain until rxs = 1, then go to IDLE; a line held low SHALL NOT generate further frames.
REQ-025 Handshake:
- A transfer occurs on any cycle with data_valid = 1 and data_ready = 1.
- data, parity_err, frame_err and overrun stay stable while data_valid = 1 and no transfer occurs.
REQ-026 Completion with data_valid = 0, or simultaneous with a transfer:
- Load the new word and flags.
- data_valid is 1 next cycle.
- overrun = 0.
REQ-027 Completion with data_valid = 1 and no transfer:
- Discard the new frame.
- Held data and error flags are unchanged.
- overrun set to 1.
REQ-028 Transfer with no simultaneous completion: data_valid = 0 the next cycle; data is retained; flags cleared to 0.
REQ-029 Latency: data_valid rises exactly 1 cycle after the last stop-bit sample cycle.
REQ-030 Receiver re-arms in IDLE immediately after a good frame; a start bit beginning right after the stop-bit midpoint is accepted.

Reset
REQ-031 With rst_n low, asynchronously:
- FSM = IDLE, counter = 0, shift register = 0.
- Synchroniser flops = 1.
- data = 0, data_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
REQ-032 Reset asserted mid-frame abandons the frame with no output; after release the block behaves as from power-up.

Verification (CLK_FREQ=16, BAUD_RATE=1 -> BAUD_COUNT=16, HALF=8 unless stated)
REQ-033 8N1 frame 0xA5 with data_ready = 1 -> exactly one data_valid pulse, data = 0xA5, all flags 0, busy low afterwards.
REQ-034 PARITY = 2, frame 0x03 with parity bit 1 -> data = 0x03, parity_err = 1; repeating with parity bit 0 -> parity_err = 0.
REQ-035 8N1 frame 0x5A with stop bit 0, rx then held low for 40 bit times -> one word 0x5A with frame_err = 1, then no further data_valid until rx rises and a new start bit arrives.
REQ-036 rx low pulse of 4 cycles from idle -> busy pulses, data_valid never asserts, FSM back in IDLE.
REQ-037 Frames 0x11, 0x22, 0x33 back-to-back with data_ready = 0, then data_ready = 1 for one cycle -> data = 0x11, overrun = 1 at transfer, data_valid falls; 0x22 and 0x33 are never presented.
REQ-038 rst_n pulsed low during data bit 3 of a frame -> all outputs 0 during reset; no word is presented; next frame 0xC3 is received with data = 0xC3 and flags 0.
